// File: rtl/serdes_pkg.sv
// serdes_pkg: shared state encoding and pattern constants for the TX pattern generator
package serdes_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, PRBS} state_t;
  localparam logic [7:0] SYNC_BYTE  = 8'hBC;
  localparam logic [7:0] FILL_BYTE  = 8'h55;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  function automatic logic prbs7_out(input logic [6:0] s);
    return s[6] ^ s[5];
  endfunction
endpackage

// File: rtl/serdes_prbs7_step.sv
// serdes_prbs7_step: combinational N-step PRBS7 (x^7+x^6+1) advance; bit k is the k-th generated bit
module serdes_prbs7_step
  import serdes_pkg::*;
#(
  parameter int STEPS = 8
) (
  input  logic [6:0]       i_state,
  output logic [STEPS-1:0] o_bits,
  output logic [6:0]       o_state
);
  logic [6:0] w_s;
  logic       w_b;
  always_comb begin
    w_s    = i_state;
    w_b    = 1'b0;
    o_bits = '0;
    for (int k = 0; k < STEPS; k++) begin
      w_b       = prbs7_out(w_s);
      o_bits[k] = w_b;
      w_s       = {w_s[5:0], w_b};
    end
    o_state = w_s;
  end
endmodule

// File: rtl/serdes_tx_pattern_gen.sv
// serdes_tx_pattern_gen: word-wide IDLE/SYNC/PRBS7 training pattern source for a TX serializer.
// Define SERDES_TX_PATTERN_ERR_INJ_EN to enable single-bit error injection on PRBS words.
module serdes_tx_pattern_gen
  import serdes_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SYNC_WORDS = 16
) (
  input  logic                  bitclk,
  input  logic                  tx_reset,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  inject_err,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  word_strobe,
  output logic                  busy,
  output logic                  sync_done
);
  localparam int CW = $clog2(DATA_WIDTH);

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt, w_sync, w_prbs_bits, w_inj;
  logic [6:0]            r_prbs, w_prbs_nxt, w_prbs_state;
  logic [7:0]            r_scnt, w_scnt_nxt;
  logic                  r_sync_done, w_done_nxt, w_bnd;

  assign w_bnd       = r_cnt == CW'(DATA_WIDTH - 1);
  assign word_strobe = w_bnd;
  assign tx_data     = r_data;
  assign busy        = r_state != IDLE;
  assign sync_done   = r_sync_done;

  always_comb begin
    w_sync = '0;
    for (int i = 0; i < DATA_WIDTH / 8; i++)
      w_sync[8*i +: 8] = (i == 0) ? SYNC_BYTE : FILL_BYTE;
  end

  serdes_prbs7_step #(.STEPS(DATA_WIDTH)) u_step (
    .i_state (r_prbs),
    .o_bits  (w_prbs_bits),
    .o_state (w_prbs_state)
  );

`ifdef SERDES_TX_PATTERN_ERR_INJ_EN
  logic r_err;
  assign w_inj = {{(DATA_WIDTH-1){1'b0}}, r_err};
  // The latch is consumed by the next PRBS word load; a pulse on that same edge arms the following word.
  always_ff @(posedge bitclk or posedge tx_reset) begin
    if (tx_reset) r_err <= 1'b0;
    else          r_err <= (r_err & ~(w_bnd & (w_state_nxt == PRBS))) | inject_err;
  end
`else
  logic w_unused_inj;
  assign w_unused_inj = inject_err;
  assign w_inj        = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_prbs_nxt  = r_prbs;
    w_scnt_nxt  = r_scnt;
    w_done_nxt  = 1'b0;
    if (w_bnd) begin
      if (r_state == IDLE) begin
        w_data_nxt = '0;
        if (enable && start) begin
          w_state_nxt = SYNC;
          w_data_nxt  = w_sync;
          w_prbs_nxt  = PRBS7_SEED;
          w_scnt_nxt  = '0;
        end
      end else if (!enable) begin
        w_state_nxt = IDLE;
        w_data_nxt  = '0;
      end else if (r_state == SYNC && r_scnt != 8'(SYNC_WORDS - 1)) begin
        w_data_nxt = w_sync;
        w_scnt_nxt = r_scnt + 8'(r_scnt != 8'hFF);
      end else begin
        w_state_nxt = PRBS;
        w_data_nxt  = w_prbs_bits ^ w_inj;
        w_prbs_nxt  = w_prbs_state;
        w_done_nxt  = r_state == SYNC;
      end
    end
  end

  always_ff @(posedge bitclk or posedge tx_reset) begin
    if (tx_reset) begin
      r_cnt       <= '0;
      r_state     <= IDLE;
      r_data      <= '0;
      r_prbs      <= PRBS7_SEED;
      r_scnt      <= '0;
      r_sync_done <= 1'b0;
    end else begin
      r_cnt       <= w_bnd ? '0 : r_cnt + 1'b1;
      r_state     <= w_state_nxt;
      r_data      <= w_data_nxt;
      r_prbs      <= w_prbs_nxt;
      r_scnt      <= w_scnt_nxt;
      r_sync_done <= w_done_nxt;
    end
  end
endmodule

// File: tb/tb_serdes_tx_pattern_gen.sv
// tb_serdes_tx_pattern_gen: checks an 8-bit and a 32-bit generator against a word-level pattern model
module tb_serdes_tx_pattern_gen;
  localparam int SW = 16;
`ifdef SERDES_TX_PATTERN_ERR_INJ_EN
  localparam bit INJ_ON = 1'b1;
`else
  localparam bit INJ_ON = 1'b0;
`endif

  logic        bitclk = 1'b0;
  logic        tx_reset;
  logic [1:0]  en, st, ij;
  logic [7:0]  d8;
  logic [31:0] d32;
  logic        s8, s32, b8, b32, sd8, sd32;

  always #5 bitclk = ~bitclk;

  serdes_tx_pattern_gen #(.DATA_WIDTH(8), .SYNC_WORDS(SW)) dut8 (
    .bitclk(bitclk), .tx_reset(tx_reset), .enable(en[0]), .start(st[0]), .inject_err(ij[0]),
    .tx_data(d8), .word_strobe(s8), .busy(b8), .sync_done(sd8)
  );
  serdes_tx_pattern_gen #(.DATA_WIDTH(32), .SYNC_WORDS(SW)) dut32 (
    .bitclk(bitclk), .tx_reset(tx_reset), .enable(en[1]), .start(st[1]), .inject_err(ij[1]),
    .tx_data(d32), .word_strobe(s32), .busy(b32), .sync_done(sd32)
  );

  int          n_chk = 0, n_fail = 0, timeouts = 0, bc = 0;
  bit          inj_burst = 1'b0;
  int          pos[2], mode[2], nsync[2], pidx[2];
  logic [31:0] ed[2];
  bit          done[2], epend[2];

  function automatic int wid(input int l);
    return (l == 0) ? 8 : 32;
  endfunction

  // PRBS7 as a bit recurrence: b[n] = b[n-7] ^ b[n-6], with the seven bits before n=0 all ones.
  function automatic bit prbs_bit(input int n);
    bit b[134];
    for (int i = 0; i < 7; i++) b[i] = 1'b1;
    for (int i = 7; i <= n + 7; i++) b[i] = b[i-7] ^ b[i-6];
    return b[n+7];
  endfunction

  function automatic logic [31:0] prbs_word(input int w, input int s);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < w; k++) r[k] = prbs_bit((s + k) % 127);
    return r;
  endfunction

  function automatic logic [31:0] sync_word(input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w / 8; i++) r[8*i +: 8] = (i == 0) ? 8'hBC : 8'h55;
    return r;
  endfunction

  always @(posedge bitclk or posedge tx_reset) begin
    for (int l = 0; l < 2; l++) begin
      bit ld;
      ld = 1'b0;
      if (tx_reset) begin
        pos[l] <= 0; mode[l] <= 0; nsync[l] <= 0; pidx[l] <= 0;
        ed[l] <= '0; done[l] <= 1'b0; epend[l] <= 1'b0;
      end else begin
        done[l] <= 1'b0;
        pos[l]  <= (pos[l] + 1) % wid(l);
        if (pos[l] == wid(l) - 1) begin
          if (mode[l] == 0) begin
            ed[l] <= '0;
            if (en[l] && st[l]) begin
              mode[l] <= 1; nsync[l] <= 1; pidx[l] <= 0; ed[l] <= sync_word(wid(l));
            end
          end else if (!en[l]) begin
            mode[l] <= 0; ed[l] <= '0;
          end else if (mode[l] == 1 && nsync[l] < SW) begin
            nsync[l] <= nsync[l] + 1; ed[l] <= sync_word(wid(l));
          end else begin
            ld = 1'b1;
            done[l] <= (mode[l] == 1);
            mode[l] <= 2;
            ed[l]   <= prbs_word(wid(l), pidx[l]) ^ {31'b0, epend[l]};
            pidx[l] <= (pidx[l] + wid(l)) % 127;
          end
        end
`ifdef SERDES_TX_PATTERN_ERR_INJ_EN
        epend[l] <= (epend[l] && !ld) || ij[l];
`endif
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge bitclk) begin
    chk("data8", {24'h0, d8}, ed[0]);
    chk("data32", d32, ed[1]);
    chk("strobe8", {31'b0, s8}, {31'b0, pos[0] == 7});
    chk("strobe32", {31'b0, s32}, {31'b0, pos[1] == 31});
    chk("busy8", {31'b0, b8}, {31'b0, mode[0] != 0});
    chk("busy32", {31'b0, b32}, {31'b0, mode[1] != 0});
    chk("sync_done8", {31'b0, sd8}, {31'b0, done[0]});
    chk("sync_done32", {31'b0, sd32}, {31'b0, done[1]});
    chk("timeouts", timeouts, 0);
    if (mode[0] == 1) chk("sync8_lit", {24'h0, d8}, 32'hBC);
    if (mode[1] == 1) chk("sync32_lit", d32, 32'h555555BC);
    if (mode[0] == 2)
      case (pidx[0])
        8:  chk("prbs8_w0", {24'h0, d8}, 32'h40);
        16: chk("prbs8_w1", {24'h0, d8}, {24'h0, 7'h18, inj_burst & INJ_ON});
        24: chk("prbs8_w2", {24'h0, d8}, 32'h14);
        32: chk("prbs8_w3", {24'h0, d8}, 32'h4F);
        default: ;
      endcase
    if (mode[1] == 2 && pidx[1] == 32) chk("prbs32_w0", d32, 32'h4F143040);
    if (sd8) chk("sync8_cycles", bc, 128);
    bc = b8 ? bc + int'(d8 == 8'hBC) : 0;
  end

  function automatic logic sig(input int l, input int w);
    case (w)
      0:       return (l != 0) ? b32 : b8;
      1:       return (l != 0) ? sd32 : sd8;
      default: return (l != 0) ? s32 : s8;
    endcase
  endfunction

  task automatic wait_hi(input int l, input int w, input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge bitclk);
      if (sig(l, w)) return;
    end
    timeouts++;
  endtask

  task automatic burst(input int l, input int words);
    en[l] = 1'b1;
    st[l] = 1'b1;
    wait_hi(l, 0, 2 * wid(l) + 2);
    st[l] = 1'b0;
    wait_hi(l, 1, (SW + 2) * wid(l));
    repeat (words * wid(l)) @(negedge bitclk);
  endtask

  initial begin
    tx_reset = 1'b1; en = '0; st = '0; ij = '0;
    repeat (3) @(negedge bitclk);
    tx_reset = 1'b0;
    repeat (24) @(negedge bitclk);
    // start pulse away from a word boundary must not launch a burst
    en[0] = 1'b1;
    wait_hi(0, 2, 16);
    repeat (2) @(negedge bitclk);
    st[0] = 1'b1;
    @(negedge bitclk);
    st[0] = 1'b0;
    repeat (16) @(negedge bitclk);
    burst(0, 10);
    en[0] = 1'b0;
    repeat (16) @(negedge bitclk);
    burst(1, 130);
    en[1] = 1'b0;
    repeat (64) @(negedge bitclk);
    // enable dropped during the fifth sync word
    en[0] = 1'b1; st[0] = 1'b1;
    wait_hi(0, 0, 18);
    st[0] = 1'b0;
    repeat (35) @(negedge bitclk);
    en[0] = 1'b0;
    repeat (24) @(negedge bitclk);
    // reset in the middle of PRBS, then a fresh burst
    burst(0, 3);
    repeat (3) @(negedge bitclk);
    #2 tx_reset = 1'b1;
    repeat (2) @(negedge bitclk);
    tx_reset = 1'b0;
    burst(0, 4);
    en[0] = 1'b0;
    repeat (16) @(negedge bitclk);
    // error injection during PRBS word 0
    inj_burst = 1'b1;
    en[0] = 1'b1; st[0] = 1'b1;
    wait_hi(0, 0, 18);
    st[0] = 1'b0;
    wait_hi(0, 1, (SW + 2) * 8);
    @(negedge bitclk);
    ij[0] = 1'b1;
    @(negedge bitclk);
    ij[0] = 1'b0;
    repeat (48) @(negedge bitclk);
    en[0] = 1'b0;
    repeat (24) @(negedge bitclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
